stream_split: RTL

- Downstream width down-converter that consumes the ready/valid stream produced by skid.
- Accepts one wide word of RATIO*OUT_WIDTH bits and emits it as RATIO narrow chunks, least-significant chunk first.
- Its irdy connects directly to skid's ordy. skid registers the upstream ready path, so the combinational ordy->irdy path here is permitted.

---
 rtl/stream_split_pkg.sv | 16 +
 rtl/stream_split.sv | 94 +++++++++
 2 files changed

// File: rtl/stream_split_pkg.sv
// Shared helpers for the stream_split width down-converter.
// Parameter-dependent types (chunk index, chunk array) live in the module.
package stream_split_pkg;

    // Width of the chunk index; never below one bit so RATIO=1 still has a counter.
    function automatic int unsigned cnt_width(input int unsigned ratio);
        int unsigned w;
        w = (ratio > 1) ? $clog2(ratio) : 1;
        return w;
    endfunction

    // Default geometry used by integration and the bench.
    localparam int unsigned DEF_OUT_WIDTH = 13;
    localparam int unsigned DEF_RATIO     = 3;

endpackage

// File: rtl/stream_split.sv
// Wide-to-narrow stream converter: one RATIO*OUT_WIDTH word out as RATIO chunks, LSB chunk first.
// Optional STREAM_SPLIT_LAST_EN adds ilast/olast framing carried with each word.
module stream_split
    import stream_split_pkg::*;
#(
    parameter  int unsigned OUT_WIDTH = DEF_OUT_WIDTH,
    parameter  int unsigned RATIO     = DEF_RATIO,
    localparam int unsigned IN_WIDTH  = OUT_WIDTH * RATIO
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  idat,
    input  logic                 ivld,
    output logic                 irdy,
`ifdef STREAM_SPLIT_LAST_EN
    input  logic                 ilast,
    output logic                 olast,
`endif
    output logic [OUT_WIDTH-1:0] odat,
    output logic                 ovld,
    input  logic                 ordy
);

    localparam int unsigned CNT_W = cnt_width(RATIO);

    typedef logic [CNT_W-1:0]                   chunk_idx_t;
    typedef logic [RATIO-1:0][OUT_WIDTH-1:0]    chunk_arr_t;

    localparam chunk_idx_t LAST_IDX = CNT_W'(RATIO - 1);

    chunk_arr_t word_q;
    chunk_idx_t cnt, cnt_d;
    logic       vld, vld_d;
    logic       last_chunk;
    logic       accept;
    logic       xfer;

    assign last_chunk = (cnt == LAST_IDX);
    assign ovld       = vld && !rst;
    assign irdy       = !rst && (!vld || (ordy && last_chunk));
    assign accept     = ivld && irdy;
    assign xfer       = ovld && ordy;
    assign odat       = word_q[cnt];

    // Next-state: output transfer advances the index, an accept overrides it.
    always_comb begin
        vld_d = vld;
        cnt_d = cnt;
        if (xfer) begin
            if (last_chunk) begin
                cnt_d = '0;
                vld_d = 1'b0;
            end else begin
                cnt_d = cnt + CNT_W'(1);
            end
        end
        if (accept) begin
            cnt_d = '0;
            vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= 1'b0;
            cnt <= '0;
        end else begin
            vld <= vld_d;
            cnt <= cnt_d;
        end
    end

    // Data word is not reset; it is only observable while vld is set.
    always_ff @(posedge clk) begin
        if (accept) begin
            word_q <= chunk_arr_t'(idat);
        end
    end

`ifdef STREAM_SPLIT_LAST_EN
    logic last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b0;
        end else if (accept) begin
            last_q <= ilast;
        end
    end

    assign olast = ovld && last_q && last_chunk;
`endif

endmodule
